// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared state encoding and default widths for pipe_stage
// Imported by pipe_stage and pipe_payload_reg.
package pipe_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_CTRL_W = 4;
   localparam int DEF_REG_W  = 5;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// rtl/pipe_payload_reg.sv - one {ctrl, data, reg} payload entry with load and clear
// Clear zeroes only the control field so data/reg keep their last value.
module pipe_payload_reg
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int REG_W  = DEF_REG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              clear,
   input  logic [CTRL_W-1:0] d_ctrl,
   input  logic [DATA_W-1:0] d_data,
   input  logic [REG_W-1:0]  d_reg,
   output logic [CTRL_W-1:0] q_ctrl,
   output logic [DATA_W-1:0] q_data,
   output logic [REG_W-1:0]  q_reg
);

   logic [CTRL_W-1:0] r_ctrl;
   logic [DATA_W-1:0] r_data;
   logic [REG_W-1:0]  r_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ctrl <= '0;
         r_data <= '0;
         r_reg  <= '0;
      end else if (load) begin
         r_ctrl <= d_ctrl;
         r_data <= d_data;
         r_reg  <= d_reg;
      end else if (clear) begin
         r_ctrl <= '0;
      end
   end

   assign q_ctrl = r_ctrl;
   assign q_data = r_data;
   assign q_reg  = r_reg;

endmodule

// File: rtl/pipe_stage.sv
// rtl/pipe_stage.sv - valid/ready pipeline stage with bubble insertion and flush
// Define PIPE_STAGE_SKID_EN for the two-entry skid buffer with registered in_ready.
module pipe_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int CTRL_W = DEF_CTRL_W,
   parameter int REG_W  = DEF_REG_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   input  logic [REG_W-1:0]  in_reg,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [REG_W-1:0]  out_reg,
   output logic [1:0]        occupancy
);

   state_t            r_state;
   state_t            w_next_state;
   logic              w_in_xfer;
   logic              w_out_xfer;
   logic              w_main_load;
   logic              w_main_clear;
   logic [CTRL_W-1:0] w_main_d_ctrl;
   logic [DATA_W-1:0] w_main_d_data;
   logic [REG_W-1:0]  w_main_d_reg;
`ifdef PIPE_STAGE_SKID_EN
   logic              r_in_ready;
   logic              w_skid_load;
   logic              w_skid_clear;
   logic              w_main_from_skid;
   logic [CTRL_W-1:0] w_skid_ctrl;
   logic [DATA_W-1:0] w_skid_data;
   logic [REG_W-1:0]  w_skid_reg;
`else
   logic              r_live;
`endif

   assign out_valid  = (r_state != EMPTY);
   assign occupancy  = r_state;
   assign w_out_xfer = out_valid & out_ready;
   assign w_in_xfer  = in_valid & in_ready;

`ifdef PIPE_STAGE_SKID_EN
   assign in_ready      = r_in_ready;
   assign w_main_d_ctrl = w_main_from_skid ? w_skid_ctrl : in_ctrl;
   assign w_main_d_data = w_main_from_skid ? w_skid_data : in_data;
   assign w_main_d_reg  = w_main_from_skid ? w_skid_reg  : in_reg;
`else
   // r_live keeps in_ready low through reset and the edge that releases it
   assign in_ready      = r_live & (~out_valid | out_ready);
   assign w_main_d_ctrl = in_ctrl;
   assign w_main_d_data = in_data;
   assign w_main_d_reg  = in_reg;
`endif

   always_comb begin
      w_next_state = r_state;
      w_main_load  = 1'b0;
      w_main_clear = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      w_skid_load      = 1'b0;
      w_skid_clear     = 1'b0;
      w_main_from_skid = 1'b0;
`endif
      if (flush) begin
         w_next_state = EMPTY;
         w_main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
         w_skid_clear = 1'b1;
`endif
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_in_xfer) begin
                  w_next_state = ONE;
                  w_main_load  = 1'b1;
               end
            end
            ONE: begin
               if (w_in_xfer && w_out_xfer) begin
                  w_main_load = 1'b1;
               end else if (w_out_xfer) begin
                  w_next_state = EMPTY;
                  w_main_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
               end else if (w_in_xfer) begin
                  w_next_state = FULL;
                  w_skid_load  = 1'b1;
`endif
               end
            end
`ifdef PIPE_STAGE_SKID_EN
            FULL: begin
               if (w_out_xfer) begin
                  w_next_state     = ONE;
                  w_main_load      = 1'b1;
                  w_main_from_skid = 1'b1;
                  w_skid_clear     = 1'b1;
               end
            end
`endif
            default: w_next_state = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
`ifdef PIPE_STAGE_SKID_EN
         r_in_ready <= 1'b0;
`else
         r_live <= 1'b0;
`endif
      end else begin
         r_state <= w_next_state;
`ifdef PIPE_STAGE_SKID_EN
         r_in_ready <= (w_next_state != FULL);
`else
         r_live <= 1'b1;
`endif
      end
   end

   pipe_payload_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_W(REG_W)) u_main (
      .clk    (clk),
      .rst    (rst),
      .load   (w_main_load),
      .clear  (w_main_clear),
      .d_ctrl (w_main_d_ctrl),
      .d_data (w_main_d_data),
      .d_reg  (w_main_d_reg),
      .q_ctrl (out_ctrl),
      .q_data (out_data),
      .q_reg  (out_reg)
   );

`ifdef PIPE_STAGE_SKID_EN
   pipe_payload_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .REG_W(REG_W)) u_skid (
      .clk    (clk),
      .rst    (rst),
      .load   (w_skid_load),
      .clear  (w_skid_clear),
      .d_ctrl (in_ctrl),
      .d_data (in_data),
      .d_reg  (in_reg),
      .q_ctrl (w_skid_ctrl),
      .q_data (w_skid_data),
      .q_reg  (w_skid_reg)
   );
`endif

endmodule

// File: tb/tb_pipe_stage.sv
// tb/tb_pipe_stage.sv - self-checking bench for pipe_stage (vectors, corner sequences, random vs queue model)
// Follows the PIPE_STAGE_SKID_EN setting of the build.
module tb_pipe_stage;

`ifdef PIPE_STAGE_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  in_ctrl = '0;
   logic [31:0] in_data = '0;
   logic [4:0]  in_reg = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [3:0]  out_ctrl;
   logic [31:0] out_data;
   logic [4:0]  out_reg;
   logic [1:0]  occupancy;

   int n_cmp = 0;
   int n_err = 0;

   pipe_stage dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_ctrl   (in_ctrl),
      .in_data   (in_data),
      .in_reg    (in_reg),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_ctrl  (out_ctrl),
      .out_data  (out_data),
      .out_reg   (out_reg),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        v, o, f;
      logic [3:0]  c;
      logic [31:0] d;
      logic [4:0]  r;
      logic        ev;
      logic [3:0]  ec;
      logic [31:0] ed;
      logic [4:0]  er;
      logic [1:0]  eo;
   } vec_t;

   typedef struct {
      logic [3:0]  c;
      logic [31:0] d;
      logic [4:0]  r;
   } beat_t;

   vec_t  tbl[8];
   beat_t q[$];
   beat_t last;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input logic v, input logic o, input logic f,
                        input logic [3:0] c, input logic [31:0] d, input logic [4:0] r);
      in_valid = v; out_ready = o; flush = f;
      in_ctrl = c; in_data = d; in_reg = r;
   endtask

   task automatic do_reset();
      @(negedge clk);
      drive(0, 0, 0, 4'h0, 32'h0, 5'h0);
      rst = 1'b1;
      #1;
      chk("rst_valid", {31'b0, out_valid}, 0);
      chk("rst_ready", {31'b0, in_ready}, 0);
      chk("rst_occ", {30'b0, occupancy}, 0);
      chk("rst_data", out_data, 0);
      chk("rst_ctrl", {28'b0, out_ctrl}, 0);
      chk("rst_reg", {27'b0, out_reg}, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rel_ready_low", {31'b0, in_ready}, 0);
      @(posedge clk);
      #1;
      chk("rel_ready_high", {31'b0, in_ready}, 1);
   endtask

   task automatic step_chk(input string nm, input logic ev, input logic [31:0] ed, input logic [1:0] eo);
      @(posedge clk);
      #1;
      chk({nm, "_valid"}, {31'b0, out_valid}, {31'b0, ev});
      chk({nm, "_data"}, out_data, ed);
      chk({nm, "_occ"}, {30'b0, occupancy}, {30'b0, eo});
      if (!ev) chk({nm, "_bubble"}, {28'b0, out_ctrl}, 0);
   endtask

   initial begin
      logic exp_rdy, do_in, do_out;
      beat_t b;

      tbl[0] = '{1, 1, 0, 4'h3, 32'h11, 5'd1, 1, 4'h3, 32'h11, 5'd1, 2'd1};
      tbl[1] = '{1, 1, 0, 4'h5, 32'h22, 5'd2, 1, 4'h5, 32'h22, 5'd2, 2'd1};
      tbl[2] = '{1, 1, 0, 4'h9, 32'h33, 5'd3, 1, 4'h9, 32'h33, 5'd3, 2'd1};
      tbl[3] = '{0, 1, 0, 4'hF, 32'h44, 5'd4, 0, 4'h0, 32'h33, 5'd3, 2'd0};
      tbl[4] = '{0, 1, 0, 4'hF, 32'h45, 5'd5, 0, 4'h0, 32'h33, 5'd3, 2'd0};
      tbl[5] = '{1, 1, 1, 4'h1, 32'h55, 5'd6, 0, 4'h0, 32'h33, 5'd3, 2'd0};
      tbl[6] = '{1, 1, 0, 4'h2, 32'h66, 5'd7, 1, 4'h2, 32'h66, 5'd7, 2'd1};
      tbl[7] = '{0, 0, 1, 4'hF, 32'h77, 5'd8, 0, 4'h0, 32'h66, 5'd7, 2'd0};

      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(tbl[i].v, tbl[i].o, tbl[i].f, tbl[i].c, tbl[i].d, tbl[i].r);
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d_valid", i), {31'b0, out_valid}, {31'b0, tbl[i].ev});
         chk($sformatf("vec%0d_ctrl", i), {28'b0, out_ctrl}, {28'b0, tbl[i].ec});
         chk($sformatf("vec%0d_data", i), out_data, tbl[i].ed);
         chk($sformatf("vec%0d_reg", i), {27'b0, out_reg}, {27'b0, tbl[i].er});
         chk($sformatf("vec%0d_occ", i), {30'b0, occupancy}, {30'b0, tbl[i].eo});
      end

      do_reset();
      if (SKID) begin
         @(negedge clk); drive(1, 1, 0, 4'h1, 32'hA0, 5'd1);
         step_chk("skid_a", 1, 32'hA0, 1);
         @(negedge clk); drive(1, 0, 0, 4'h2, 32'hB0, 5'd2);
         #1 chk("skid_rdy_one", {31'b0, in_ready}, 1);
         step_chk("skid_full", 1, 32'hA0, 2);
         chk("skid_rdy_full", {31'b0, in_ready}, 0);
         @(negedge clk); drive(0, 1, 0, 4'h0, 32'h0, 5'd0);
         step_chk("skid_b", 1, 32'hB0, 1);
         step_chk("skid_drain", 0, 32'hB0, 0);
         @(negedge clk); drive(1, 0, 0, 4'h1, 32'hC1, 5'd1);
         step_chk("fl_c1", 1, 32'hC1, 1);
         @(negedge clk); drive(1, 0, 0, 4'h2, 32'hC2, 5'd2);
         step_chk("fl_full", 1, 32'hC1, 2);
         @(negedge clk); drive(1, 0, 1, 4'h3, 32'hCC, 5'd3);
         step_chk("fl_flush", 0, 32'hC1, 0);
         @(negedge clk); drive(0, 1, 0, 4'h0, 32'h0, 5'd0);
         for (int i = 0; i < 3; i++) step_chk("fl_after", 0, 32'hC1, 0);
         @(negedge clk); drive(1, 0, 0, 4'h1, 32'hD1, 5'd1);
         step_chk("rs_d1", 1, 32'hD1, 1);
         @(negedge clk); drive(1, 0, 0, 4'h2, 32'hD2, 5'd2);
         step_chk("rs_full", 1, 32'hD1, 2);
      end else begin
         @(negedge clk); drive(1, 1, 0, 4'h1, 32'hE1, 5'd1);
         step_chk("ns_e1", 1, 32'hE1, 1);
         @(negedge clk); drive(1, 0, 0, 4'h2, 32'hE2, 5'd2);
         #1 chk("ns_rdy_stall", {31'b0, in_ready}, 0);
         step_chk("ns_hold", 1, 32'hE1, 1);
         @(negedge clk); out_ready = 1'b1;
         #1 chk("ns_rdy_go", {31'b0, in_ready}, 1);
         step_chk("ns_e2", 1, 32'hE2, 1);
         @(negedge clk); drive(0, 0, 0, 4'h0, 32'h0, 5'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_valid", {31'b0, out_valid}, 0);
      chk("mid_rst_occ", {30'b0, occupancy}, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_ready", {31'b0, in_ready}, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 1, 0, 4'h0, 32'h0, 5'd0);
      #1 chk("mid_rel_low", {31'b0, in_ready}, 0);
      @(posedge clk);
      #1 chk("mid_rel_high", {31'b0, in_ready}, 1);

      do_reset();
      q.delete();
      last = '{4'h0, 32'h0, 5'h0};
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         drive($urandom_range(0, 1), ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
               4'($urandom), $urandom, 5'($urandom));
         #1;
         exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || out_ready);
         chk("rnd_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
         chk("rnd_valid", {31'b0, out_valid}, {31'b0, (q.size() > 0)});
         chk("rnd_occ", {30'b0, occupancy}, q.size());
         chk("rnd_ctrl", {28'b0, out_ctrl}, (q.size() > 0) ? {28'b0, q[0].c} : 32'h0);
         chk("rnd_data", out_data, last.d);
         chk("rnd_reg", {27'b0, out_reg}, {27'b0, last.r});
         do_out = (q.size() > 0) && out_ready;
         do_in  = in_valid && exp_rdy;
         b = '{in_ctrl, in_data, in_reg};
         @(posedge clk);
         if (do_out) void'(q.pop_front());
         if (flush) q.delete();
         else if (do_in) q.push_back(b);
         if (q.size() > 0) last = q[0];
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
